// File: rtl/spi_tx.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : spi_tx
// Description : SPI master transmitter, 8/16-bit frames MSB first, selectable
//               sampling edge, full-duplex MISO capture on the sample edge.
// Revision    : 1.0 - initial release
// ============================================================================
module spi_tx #(
   parameter int SCLK_DIV = 8
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        wrt,
   input  logic [15:0] tx_data,
   input  logic        len8_16,
   input  logic        edg,
   input  logic        MISO,
   output logic        SS_n,
   output logic        SCLK,
   output logic        MOSI,
   output logic [15:0] rx_data,
   output logic        busy,
   output logic        done
);

   localparam int HALF = SCLK_DIV / 2;
   localparam int HW   = (HALF > 1) ? $clog2(HALF) : 1;
   localparam logic [HW-1:0] C_HALF_LAST = HW'(HALF - 1);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      FRONT = 3'd1,
      SHIFT = 3'd2,
      BACK  = 3'd3,
      GAP   = 3'd4
   } state_t;

   state_t        r_state;
   state_t        w_state_nxt;
   logic [HW-1:0] r_half_cnt;
   logic          r_phase;      // 0 = launch half of a bit, 1 = sample half
   logic [4:0]    r_bit_cnt;    // completed sample edges in this frame
   logic [15:0]   r_tx_shift;   // next bit to send is always in [15]
   logic [15:0]   r_rx_shift;
   logic          r_len8;
   logic          r_edg;

   logic          w_half_end;
   logic          w_sample;
   logic          w_bit_end;
   logic          w_last_bit;
   logic [4:0]    w_nbits;

   logic          w_ss_n_nxt;
   logic          w_sclk_nxt;
   logic          w_mosi_nxt;
   logic          w_busy_nxt;
   logic          w_done_nxt;

   assign w_half_end = (r_half_cnt == C_HALF_LAST);
   assign w_nbits    = r_len8 ? 5'd8 : 5'd16;
   // The SCLK flop moves to the sample level on the edge after the first
   // cycle of the sample half, so MISO is captured on that same edge.
   assign w_sample   = (r_state == SHIFT) && r_phase && (r_half_cnt == '0);
   assign w_bit_end  = (r_state == SHIFT) && r_phase && w_half_end;
   assign w_last_bit = (r_bit_cnt == w_nbits);

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= IDLE;
      else        r_state <= w_state_nxt;
   end

   // Next-state and next-output decode; outputs are registered one clk later
   always_comb begin
      w_state_nxt = r_state;
      w_ss_n_nxt  = 1'b1;
      w_sclk_nxt  = r_edg;
      w_mosi_nxt  = MOSI;
      w_busy_nxt  = 1'b1;
      w_done_nxt  = 1'b0;
      case (r_state)
         IDLE: begin
            w_busy_nxt = 1'b0;
            w_sclk_nxt = edg;
            if (wrt) w_state_nxt = FRONT;
         end
         FRONT: begin
            w_ss_n_nxt = 1'b0;
            w_mosi_nxt = r_tx_shift[15];
            if (w_half_end) w_state_nxt = SHIFT;
         end
         SHIFT: begin
            w_ss_n_nxt = 1'b0;
            w_sclk_nxt = r_phase ? r_edg : ~r_edg;
            w_mosi_nxt = r_tx_shift[15];
            if (w_bit_end && w_last_bit) w_state_nxt = BACK;
         end
         BACK: begin
            w_ss_n_nxt = 1'b0;
            w_mosi_nxt = r_tx_shift[15];
            if (w_half_end) w_state_nxt = GAP;
         end
         GAP: begin
            w_done_nxt = (r_half_cnt == '0);
            if (w_half_end) w_state_nxt = IDLE;
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   // Half-period, phase and bit counters; all cleared on any state change
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_half_cnt <= '0;
         r_phase    <= 1'b0;
         r_bit_cnt  <= 5'd0;
      end else if (w_state_nxt != r_state) begin
         r_half_cnt <= '0;
         r_phase    <= 1'b0;
         r_bit_cnt  <= 5'd0;
      end else if (r_state != IDLE) begin
         r_half_cnt <= w_half_end ? '0 : r_half_cnt + HW'(1);
         if ((r_state == SHIFT) && w_half_end) r_phase <= ~r_phase;
         if (w_sample) r_bit_cnt <= r_bit_cnt + 5'd1;
      end
   end

   // Frame configuration capture and shift registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_tx_shift <= 16'h0000;
         r_rx_shift <= 16'h0000;
         r_len8     <= 1'b0;
         r_edg      <= 1'b0;
      end else if ((r_state == IDLE) && wrt) begin
         r_tx_shift <= len8_16 ? {tx_data[7:0], 8'h00} : tx_data;
         r_rx_shift <= 16'h0000;
         r_len8     <= len8_16;
         r_edg      <= edg;
      end else begin
         if (w_bit_end && !w_last_bit) r_tx_shift <= {r_tx_shift[14:0], 1'b0};
         if (w_sample)                 r_rx_shift <= {r_rx_shift[14:0], MISO};
      end
   end

   // Output flops, including the received word published with done
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         SS_n    <= 1'b1;
         SCLK    <= 1'b0;
         MOSI    <= 1'b0;
         busy    <= 1'b0;
         done    <= 1'b0;
         rx_data <= 16'h0000;
      end else begin
         SS_n <= w_ss_n_nxt;
         SCLK <= w_sclk_nxt;
         MOSI <= w_mosi_nxt;
         busy <= w_busy_nxt;
         done <= w_done_nxt;
         if (w_done_nxt)
            rx_data <= r_len8 ? {8'h00, r_rx_shift[7:0]} : r_rx_shift;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_spi_tx.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_spi_tx
// Description : Scoreboard bench for spi_tx. Stimulus pushes frame
//               descriptors; a monitor decodes the SPI pins and compares.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_spi_tx;

   localparam int SCLK_DIV = 8;
   localparam int HALF     = SCLK_DIV / 2;

   logic        clk = 1'b0;
   logic        rst_n, wrt, len8_16, edg, MISO;
   logic [15:0] tx_data;
   logic        SS_n, SCLK, MOSI, busy, done;
   logic [15:0] rx_data;
   logic [1:0]  miso_mode;   // 0 loopback, 1 inverted loopback, 2 zero, 3 one

   spi_tx #(.SCLK_DIV(SCLK_DIV)) dut (
      .clk(clk), .rst_n(rst_n), .wrt(wrt), .tx_data(tx_data),
      .len8_16(len8_16), .edg(edg), .MISO(MISO), .SS_n(SS_n), .SCLK(SCLK),
      .MOSI(MOSI), .rx_data(rx_data), .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   // Slave model
   always_comb begin
      case (miso_mode)
         2'd0:    MISO = MOSI;
         2'd1:    MISO = ~MOSI;
         2'd2:    MISO = 1'b0;
         default: MISO = 1'b1;
      endcase
   end

   typedef struct {
      logic        len8;
      logic        edg;
      logic [15:0] data;
      logic [1:0]  mode;
      bit          chk_gap;
   } item_t;

   item_t exp_q[$];
   int    n_cmp  = 0;
   int    n_fail = 0;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] expv);
      n_cmp++;
      if (got !== expv) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, expv, $time);
      end
   endtask

   task automatic timeout_fail(input string name);
      n_cmp++;
      n_fail++;
      $display("FAIL %s: timed out at %0t", name, $time);
   endtask

   // Reference model: frame contents from the payload rules alone
   function automatic logic [15:0] exp_bits(input item_t it);
      return it.len8 ? {8'h00, it.data[7:0]} : it.data;
   endfunction

   function automatic logic [15:0] exp_rx(input item_t it);
      logic [15:0] mask;
      mask = it.len8 ? 16'h00FF : 16'hFFFF;
      case (it.mode)
         2'd0:    return exp_bits(it);
         2'd1:    return ~exp_bits(it) & mask;
         2'd2:    return 16'h0000;
         default: return mask;
      endcase
   endfunction

   function automatic int nbits(input item_t it);
      return it.len8 ? 8 : 16;
   endfunction

   // Monitor state
   item_t       cur;
   bit          in_frame   = 0;
   bit          seen_frame = 0;
   int          low_cnt, samp_cnt, launch_cnt;
   int          high_cnt = 0, busy_low = 0;
   int          frames_started = 0, done_cnt = 0;
   logic [15:0] got_bits;
   logic        prev_ss = 1'b1, prev_sclk = 1'b0, prev_mosi = 1'b0;

   // Monitor: decodes pins on the falling clk edge and checks against the queue
   always @(negedge clk) begin
      if (!rst_n) begin
         in_frame   = 0;
         seen_frame = 0;
         high_cnt   = 0;
         busy_low   = 0;
      end else begin
         if (done) done_cnt++;
         if (prev_ss && !SS_n) begin
            frames_started++;
            check("frame_expected", 32'(exp_q.size() > 0), 32'd1);
            if (exp_q.size() > 0) begin
               cur        = exp_q.pop_front();
               in_frame   = 1;
               low_cnt    = 0;
               samp_cnt   = 0;
               launch_cnt = 0;
               got_bits   = 16'h0000;
               if (cur.chk_gap && seen_frame) begin
                  check("gap_ss_high_clks", 32'(high_cnt), 32'(HALF + 1));
                  check("gap_busy_low_clks", 32'(busy_low), 32'd1);
               end
               check("front_sclk_idle", 32'(SCLK), 32'(cur.edg));
            end
         end else if (in_frame && !SS_n) begin
            if (SCLK != prev_sclk) begin
               if (SCLK == cur.edg) begin
                  samp_cnt++;
                  got_bits = {got_bits[14:0], MOSI};
               end else begin
                  launch_cnt++;
               end
            end
            if ((MOSI != prev_mosi) && !((SCLK != prev_sclk) && (SCLK != cur.edg)))
               check("mosi_only_on_launch", 32'(MOSI), 32'(prev_mosi));
         end
         if (in_frame && !SS_n) low_cnt++;

         if (in_frame && !prev_ss && SS_n) begin
            check("ss_low_clks", 32'(low_cnt), 32'(HALF + nbits(cur) * SCLK_DIV + HALF));
            check("sample_edges", 32'(samp_cnt), 32'(nbits(cur)));
            check("launch_edges", 32'(launch_cnt), 32'(nbits(cur)));
            check("mosi_bits", 32'(got_bits), 32'(exp_bits(cur)));
            check("done_at_ss_rise", 32'(done), 32'd1);
            check("rx_data", 32'(rx_data), 32'(exp_rx(cur)));
            in_frame   = 0;
            seen_frame = 1;
            high_cnt   = 0;
            busy_low   = 0;
         end else if (done) begin
            check("done_only_at_frame_end", 32'(done), 32'd0);
         end
         if (SS_n) begin
            high_cnt++;
            if (!busy) busy_low++;
         end
      end
      prev_ss   = SS_n;
      prev_sclk = SCLK;
      prev_mosi = MOSI;
   end

   task automatic wait_idle(input string name);
      int t = 0;
      while ((busy !== 1'b0) && (t < 3000)) begin
         @(negedge clk);
         t++;
      end
      if (t >= 3000) timeout_fail(name);
   endtask

   task automatic start_frame(input logic l8, input logic e, input logic [15:0] d,
                              input logic [1:0] m);
      item_t it;
      int t;
      wait_idle("start_wait_idle");
      len8_16   = l8;
      edg       = e;
      tx_data   = d;
      miso_mode = m;
      it.len8 = l8; it.edg = e; it.data = d; it.mode = m; it.chk_gap = 0;
      exp_q.push_back(it);
      wrt = 1'b1;
      @(negedge clk);
      wrt = 1'b0;
      t = 0;
      while ((busy !== 1'b1) && (t < 10)) begin
         @(negedge clk);
         t++;
      end
      if (t >= 10) timeout_fail("busy_after_accept");
   endtask

   task automatic wait_done(input string name);
      int t = 0;
      while (((exp_q.size() != 0) || in_frame || (busy !== 1'b0)) && (t < 3000)) begin
         @(negedge clk);
         t++;
      end
      if (t >= 3000) timeout_fail(name);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int    d0, f0, t;
      item_t it;
      rst_n = 1'b0; wrt = 1'b0; len8_16 = 1'b0; edg = 1'b0;
      tx_data = 16'h0000; miso_mode = 2'd0;
      repeat (3) @(negedge clk);
      check("reset_ss_n", 32'(SS_n), 32'd1);
      check("reset_sclk", 32'(SCLK), 32'd0);
      check("reset_mosi", 32'(MOSI), 32'd0);
      check("reset_rx_data", 32'(rx_data), 32'd0);
      check("reset_busy", 32'(busy), 32'd0);
      check("reset_done", 32'(done), 32'd0);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      // 16-bit, rising-edge sampling, loopback
      start_frame(1'b0, 1'b1, 16'hA5C3, 2'd0);
      wait_done("frame_a5c3");

      // 8-bit, falling-edge sampling, MISO high; idle level low first
      edg = 1'b0;
      repeat (3) @(negedge clk);
      check("idle_sclk_edg0", 32'(SCLK), 32'd0);
      start_frame(1'b1, 1'b0, 16'h1234, 2'd3);
      wait_done("frame_1234");

      // Start request during a frame is ignored
      d0 = done_cnt;
      start_frame(1'b0, 1'b1, 16'h3C96, 2'd2);
      repeat (40) @(negedge clk);
      tx_data = 16'hFFFF;
      wrt = 1'b1;
      @(negedge clk);
      wrt = 1'b0;
      wait_done("frame_ignored_wrt");
      repeat (10) @(negedge clk);
      check("single_done_ignored_wrt", 32'(done_cnt - d0), 32'd1);

      // Back-to-back frames with wrt held high
      wait_idle("b2b_idle");
      len8_16 = 1'b1; edg = 1'b1; tx_data = 16'h005A; miso_mode = 2'd0;
      for (int i = 0; i < 3; i++) begin
         it.len8 = 1'b1; it.edg = 1'b1; it.data = 16'h005A; it.mode = 2'd0;
         it.chk_gap = (i != 0);
         exp_q.push_back(it);
      end
      f0 = frames_started;
      wrt = 1'b1;
      t = 0;
      while ((frames_started < f0 + 3) && (t < 2000)) begin
         @(negedge clk);
         t++;
      end
      if (t >= 2000) timeout_fail("b2b_frames");
      wrt = 1'b0;
      wait_done("b2b_done");

      // Inputs changed mid-frame have no effect; new idle level after frame
      start_frame(1'b0, 1'b1, 16'h6E1B, 2'd1);
      repeat (40) @(negedge clk);
      edg = 1'b0; len8_16 = 1'b1; tx_data = 16'h0000;
      wait_done("edg_change_frame");
      repeat (2) @(negedge clk);
      check("idle_sclk_after_edg_change", 32'(SCLK), 32'd0);

      // Randomized frames
      for (int i = 0; i < 16; i++) begin
         start_frame(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                     16'($urandom), 2'($urandom_range(0, 3)));
         repeat ($urandom_range(0, 3)) @(negedge clk);
      end
      wait_done("random_frames");

      // Asynchronous reset in the middle of a frame
      start_frame(1'b0, 1'b1, 16'hBEEF, 2'd0);
      repeat (50) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("midreset_ss_n", 32'(SS_n), 32'd1);
      check("midreset_sclk", 32'(SCLK), 32'd0);
      check("midreset_mosi", 32'(MOSI), 32'd0);
      check("midreset_busy", 32'(busy), 32'd0);
      check("midreset_done", 32'(done), 32'd0);
      exp_q.delete();
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      d0 = done_cnt;
      repeat (200) @(negedge clk);
      check("no_done_after_reset", 32'(done_cnt - d0), 32'd0);
      check("ss_high_after_reset", 32'(SS_n), 32'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/spi_tx.md
Name: spi_tx

Overview:
SPI master transmitter for the logic-analyzer stimulus path. It generates SS_n, SCLK and MOSI frames of 8 or 16 bits, MSB first. The sampling edge is selectable so the frames exercise both edge settings of the SPI trigger/capture logic. MISO is shifted in on the same sampling edge, which gives full-duplex operation and makes MOSI-to-MISO loopback checking possible.

Parameters:
SCLK_DIV, 8, system clocks per SCLK period; must be even and >= 4; HALF = SCLK_DIV/2.

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
wrt  input  1  start request; sampled only when idle
tx_data  input  16  frame payload; latched on accepted wrt
len8_16  input  1  1 = 8-bit frame (tx_data[7:0]), 0 = 16-bit frame; latched on wrt
edg  input  1  1 = receiver samples on SCLK rise, 0 = on fall; latched on wrt
MISO  input  1  serial data in
SS_n  output  1  active-low slave select
SCLK  output  1  serial clock
MOSI  output  1  serial data out
rx_data  output  16  received frame; valid when done pulses
busy  output  1  high from accept through end of inter-frame gap
done  output  1  one-clk pulse at frame end

Behaviour:
- Clock and reset: clk, with rst_n asynchronous and active-low.
- Registered outputs: all outputs come straight from flops, so there are no glitches.
- Reset values: SS_n=1, SCLK=0, MOSI=0, rx_data=0, busy=0, done=0, state=IDLE, counters=0.
- Reset mid-frame: all of the above take effect immediately, the frame is abandoned, and no done pulse is issued.
- Idle level:
  - in IDLE, SCLK is registered from the live edg input, so it idles high for edg=1 and low for edg=0;
  - during a frame, the latched edg is used.
- Bit period: every bit is a launch edge (SCLK to ~edg) followed HALF clks later by a sample edge (SCLK back to edg).
  - MOSI changes only together with a launch edge, or at frame start.
  - MISO is shifted into rx shift register bit 0 on each sample edge.
- FSM states:
  - IDLE: busy=0. wrt=1 loads tx_shift, latches len8_16/edg, clears the rx shift register and goes to FRONT. If wrt is asserted while not IDLE it is ignored, with no queueing.
  - FRONT (HALF clks): SS_n=0, SCLK=idle level, MOSI=first bit (tx_data[15] for 16-bit, tx_data[7] for 8-bit).
  - SHIFT (N*SCLK_DIV clks, N=8 or 16):
    - first HALF clks of each bit: SCLK=~edg; second HALF: SCLK=edg;
    - at each bit boundary except the last, tx_shift advances and MOSI takes the next bit;
    - 5-bit counter bit_cnt counts completed sample edges; SHIFT exits after the Nth bit period.
  - BACK (HALF clks): SCLK=edg, SS_n=0, MOSI holds the last bit.
  - GAP (HALF clks):
    - SS_n=1, and done=1 in the first GAP cycle only;
    - rx_data is updated in that same cycle, with the upper byte zeroed in 8-bit mode;
    - busy stays 1, then the FSM returns to IDLE.
- Latency: wrt accepted at clock edge k gives SS_n=0 from edge k+1.
  - SS_n low for exactly HALF + N*SCLK_DIV + HALF clks.
  - done at edge k+1+that count.
  - Next frame accepted no earlier than HALF clks after SS_n rises.
- wrt held high continuously: back-to-back frames separated by exactly HALF clks of SS_n high plus 1 IDLE clk.
- Exactly N sample edges and N launch edges per frame; no SCLK edge while SS_n=1, except an idle-level change caused by edg.
- Changing tx_data, len8_16 or edg during a frame has no effect on that frame.
- Half-period counter width is clog2(HALF); all counters reset on every state transition.

Test Plan:
- Reset: assert rst_n=0 mid-frame (SCLK_DIV=8, 16-bit) -> SS_n=1, SCLK=0, MOSI=0, busy=0, done=0 within the same cycle; no done after release.
- 16-bit, edg=1, tx_data=0xA5C3, MISO looped from MOSI -> SS_n low 136 clks; 16 SCLK rises; MOSI at the rises reads 1,0,1,0,0,1,0,1,1,1,0,0,0,0,1,1; done pulse; rx_data=0xA5C3.
- 8-bit, edg=0, tx_data=0x1234, MISO tied 1 -> SCLK idles low; 8 falls carry 0x34 MSB first; SS_n low 72 clks; rx_data=0x00FF.
- wrt pulsed again mid-frame with tx_data=0xFFFF -> ignored; the frame completes with the original data and exactly one done.
- wrt held high, 8-bit, edg=1, tx_data=0x5A -> consecutive frames identical; SS_n high between frames = 5 clks; busy low 1 clk per frame.
- edg change during SHIFT (1->0) -> current frame keeps rising-edge sampling; the following IDLE shows SCLK=0.
